// File: rtl/icache_dn_responder.sv
// icache_dn_responder: downstream-memory responder for the icache miss path.
// Accepts line-fill requests tagged with an MSHR id, holds up to DEPTH of
// them, and returns each line as a BEATS-beat burst after a countdown.
// Optional feature macro: ICACHE_DN_VAR_LAT_EN
//   undefined: fixed LATENCY, strict FIFO service, in-order return.
//   defined:   LATENCY + addr[7:6] extra cycles, lowest-free-slot allocation,
//              lowest-eligible-slot service (out-of-order return).
module icache_dn_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 3,
  parameter int DATA_WIDTH = 256,
  parameter int BEATS      = 2,
  parameter int DEPTH      = 8,
  parameter int LATENCY    = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       txreq_vld,
  output logic                                       txreq_rdy,
  input  logic [ADDR_WIDTH-1:0]                      txreq_addr,
  input  logic [ID_WIDTH-1:0]                        txreq_id,
  output logic                                       rxdat_vld,
  input  logic                                       rxdat_rdy,
  output logic [DATA_WIDTH-1:0]                      rxdat_data,
  output logic [ID_WIDTH-1:0]                        rxdat_id,
  output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] rxdat_beat,
  output logic                                       rxdat_last,
  output logic [$clog2(DEPTH):0]                     occupancy
);

  localparam int PW    = $clog2(DEPTH);
  localparam int OCC_W = PW + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(BEATS * DATA_WIDTH / 8);
  localparam int LAW   = ADDR_WIDTH - OFF_W;
  localparam int AX    = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
  localparam int LANES = DATA_WIDTH / 32;
`ifdef ICACHE_DN_VAR_LAT_EN
  localparam int CD_W  = $clog2(LATENCY + 3) + 1;
`else
  localparam int CD_W  = $clog2(LATENCY) + 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Beat payload: lane k of beat b = line_base + b*bytes_per_beat + 4*k.
  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [LAW-1:0] line,
                                                      input logic [BW-1:0]  beat);
    logic [AX-1:0]         ext;
    logic [31:0]           base;
    logic [DATA_WIDTH-1:0] d;
    ext  = AX'({line, {OFF_W{1'b0}}});
    base = ext[31:0];
    d    = '0;
    for (int k = 0; k < LANES; k++) begin
      d[32*k +: 32] = base + 32'(beat) * 32'(DATA_WIDTH / 8) + 32'(4 * k);
    end
    return d;
  endfunction

  logic [DEPTH-1:0]    slot_vld_r;
  logic [LAW-1:0]      slot_addr_r [DEPTH];
  logic [ID_WIDTH-1:0] slot_id_r   [DEPTH];
  logic [CD_W-1:0]     slot_cd_r   [DEPTH];

  state_e              state_r, state_n;
  logic [PW-1:0]       cur_r, cur_n;
  logic [BW-1:0]       beat_r, beat_n;
  logic [OCC_W-1:0]    occ_r, occ_n;
  logic                txreq_rdy_r;
  logic                rxdat_vld_r, rxdat_last_r;
  logic [DATA_WIDTH-1:0] rxdat_data_r;
  logic [ID_WIDTH-1:0] rxdat_id_r;
  logic [BW-1:0]       rxdat_beat_r;

  logic                accept_s, hs_s, last_hs_s, sel_vld_s;
  logic [DEPTH-1:0]    elig_s;
  logic [PW-1:0]       alloc_s, sel_s;
  logic [CD_W-1:0]     load_s;
  logic                unused_s;

`ifndef ICACHE_DN_VAR_LAT_EN
  logic [PW-1:0]       head_r, tail_r;
`endif

  // Offset bits below the line are don't-care on the request address.
  assign unused_s = ^txreq_addr[OFF_W-1:0];

  // Handshakes, allocation, slot selection and burst next-state.
  always_comb begin
    accept_s  = txreq_vld && txreq_rdy_r;
    hs_s      = rxdat_vld_r && rxdat_rdy;
    last_hs_s = hs_s && rxdat_last_r;
    // A slot is picked one cycle before its countdown hits zero so that the
    // registered beat lands exactly on the zero cycle.
    for (int i = 0; i < DEPTH; i++) begin
      elig_s[i] = slot_vld_r[i] && (slot_cd_r[i] <= CD_W'(1));
    end
`ifdef ICACHE_DN_VAR_LAT_EN
    load_s    = CD_W'(LATENCY) + CD_W'(txreq_addr[7:6]);
    alloc_s   = '0;
    sel_s     = '0;
    sel_vld_s = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!slot_vld_r[i]) begin
        alloc_s = PW'(i);
      end else begin
        alloc_s = alloc_s;
      end
      if (elig_s[i] && !((state_r == ST_SEND) && (cur_r == PW'(i)))) begin
        sel_s     = PW'(i);
        sel_vld_s = 1'b1;
      end else begin
        sel_s     = sel_s;
      end
    end
`else
    load_s    = CD_W'(LATENCY);
    alloc_s   = tail_r;
    // While sending, the slot after the head is the next in line.
    sel_s     = (state_r == ST_SEND) ? (head_r + PW'(1)) : head_r;
    sel_vld_s = elig_s[sel_s];
`endif
    state_n = state_r;
    cur_n   = cur_r;
    beat_n  = beat_r;
    case (state_r)
      ST_IDLE: begin
        if (sel_vld_s) begin
          state_n = ST_SEND;
          cur_n   = sel_s;
          beat_n  = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (last_hs_s) begin
          if (sel_vld_s) begin
            state_n = ST_SEND;
            cur_n   = sel_s;
            beat_n  = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (hs_s) begin
          beat_n = beat_r + BW'(1);
        end else begin
          beat_n = beat_r;
        end
      end
      // Selection is folded into IDLE; SEL is never entered and recovers.
      ST_SEL:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    occ_n = occ_r + OCC_W'(accept_s) - OCC_W'(last_hs_s);
  end

  // Slot storage: fill on accept, free on last beat, run countdowns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_addr_r[i] <= '0;
        slot_id_r[i]   <= '0;
        slot_cd_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (accept_s && (alloc_s == PW'(i))) begin
          slot_vld_r[i]  <= 1'b1;
          slot_addr_r[i] <= txreq_addr[ADDR_WIDTH-1:OFF_W];
          slot_id_r[i]   <= txreq_id;
          slot_cd_r[i]   <= load_s;
        end else begin
          if (last_hs_s && (cur_r == PW'(i))) begin
            slot_vld_r[i] <= 1'b0;
          end
          if (slot_cd_r[i] != '0) begin
            slot_cd_r[i] <= slot_cd_r[i] - CD_W'(1);
          end
        end
      end
    end
  end

`ifndef ICACHE_DN_VAR_LAT_EN
  // FIFO pointers: tail advances on accept, head on last-beat handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      if (accept_s)  tail_r <= tail_r + PW'(1);
      if (last_hs_s) head_r <= head_r + PW'(1);
    end
  end
`endif

  // Occupancy and ready; ready looks only at next registered occupancy so a
  // completion while full frees the slot one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r       <= '0;
      txreq_rdy_r <= 1'b0;
    end else begin
      occ_r       <= occ_n;
      txreq_rdy_r <= (occ_n != OCC_W'(DEPTH));
    end
  end

  // Burst state, current slot and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cur_r   <= '0;
      beat_r  <= '0;
    end else begin
      state_r <= state_n;
      cur_r   <= cur_n;
      beat_r  <= beat_n;
    end
  end

  // Registered beat outputs, held stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxdat_vld_r  <= 1'b0;
      rxdat_id_r   <= '0;
      rxdat_beat_r <= '0;
      rxdat_last_r <= 1'b0;
      rxdat_data_r <= '0;
    end else if (state_n == ST_SEND) begin
      rxdat_vld_r  <= 1'b1;
      rxdat_id_r   <= slot_id_r[cur_n];
      rxdat_beat_r <= beat_n;
      rxdat_last_r <= (beat_n == BW'(BEATS - 1));
      rxdat_data_r <= beat_data(slot_addr_r[cur_n], beat_n);
    end else begin
      rxdat_vld_r  <= 1'b0;
      rxdat_id_r   <= '0;
      rxdat_beat_r <= '0;
      rxdat_last_r <= 1'b0;
      rxdat_data_r <= '0;
    end
  end

  assign txreq_rdy  = txreq_rdy_r;
  assign rxdat_vld  = rxdat_vld_r;
  assign rxdat_data = rxdat_data_r;
  assign rxdat_id   = rxdat_id_r;
  assign rxdat_beat = rxdat_beat_r;
  assign rxdat_last = rxdat_last_r;
  assign occupancy  = occ_r;

endmodule

// File: tb/tb_icache_dn_responder.sv
// Directed self-checking bench for icache_dn_responder (default parameters).
module tb_icache_dn_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         txreq_vld = 1'b0;
  logic         txreq_rdy;
  logic [31:0]  txreq_addr = 32'h0;
  logic [2:0]   txreq_id = 3'd0;
  logic         rxdat_vld;
  logic         rxdat_rdy = 1'b0;
  logic [255:0] rxdat_data;
  logic [2:0]   rxdat_id;
  logic [0:0]   rxdat_beat;
  logic         rxdat_last;
  logic [3:0]   occupancy;

  int checks = 0;
  int errors = 0;

  icache_dn_responder #(
    .ADDR_WIDTH(32), .ID_WIDTH(3), .DATA_WIDTH(256),
    .BEATS(2), .DEPTH(8), .LATENCY(4)
  ) dut (
    .clk(clk), .rst(rst),
    .txreq_vld(txreq_vld), .txreq_rdy(txreq_rdy),
    .txreq_addr(txreq_addr), .txreq_id(txreq_id),
    .rxdat_vld(rxdat_vld), .rxdat_rdy(rxdat_rdy),
    .rxdat_data(rxdat_data), .rxdat_id(rxdat_id),
    .rxdat_beat(rxdat_beat), .rxdat_last(rxdat_last),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick();
    tick();
    checks++; if (txreq_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", txreq_rdy); end
    checks++; if (rxdat_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", rxdat_vld); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (rxdat_data !== 256'd0 || rxdat_last !== 1'b0) begin errors++; $display("FAIL reset_data got %h/%b exp 0", rxdat_data[31:0], rxdat_last); end
    rst = 1'b0;
    tick();
    checks++; if (txreq_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy_rise got %b exp 1", txreq_rdy); end
  endtask

  task automatic test_single;
    rxdat_rdy = 1'b1;
    txreq_vld = 1'b1; txreq_addr = 32'h1000; txreq_id = 3'd3;
    tick();   // T+1
    txreq_vld = 1'b0;
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL single_occ1 got %0d exp 1", occupancy); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++; if (rxdat_vld !== 1'b0) begin errors++; $display("FAIL single_early cyc T+%0d got vld=%b exp 0", c, rxdat_vld); end
    end
    tick();   // T+5: beat 0
    checks++; if (rxdat_vld !== 1'b1 || rxdat_id !== 3'd3 || rxdat_beat !== 1'b0 || rxdat_last !== 1'b0)
      begin errors++; $display("FAIL single_b0 got vld=%b id=%0d beat=%0d last=%b exp 1/3/0/0", rxdat_vld, rxdat_id, rxdat_beat, rxdat_last); end
    checks++; if (rxdat_data[31:0] !== 32'h1000 || rxdat_data[255:224] !== 32'h101C)
      begin errors++; $display("FAIL single_b0_data got %h/%h exp 00001000/0000101c", rxdat_data[31:0], rxdat_data[255:224]); end
    tick();   // T+6: beat 1
    checks++; if (rxdat_vld !== 1'b1 || rxdat_beat !== 1'b1 || rxdat_last !== 1'b1 || rxdat_id !== 3'd3)
      begin errors++; $display("FAIL single_b1 got vld=%b id=%0d beat=%0d last=%b exp 1/3/1/1", rxdat_vld, rxdat_id, rxdat_beat, rxdat_last); end
    checks++; if (rxdat_data[31:0] !== 32'h1020 || rxdat_data[63:32] !== 32'h1024)
      begin errors++; $display("FAIL single_b1_data got %h/%h exp 00001020/00001024", rxdat_data[31:0], rxdat_data[63:32]); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL single_occ_hold got %0d exp 1", occupancy); end
    tick();   // T+7
    checks++; if (rxdat_vld !== 1'b0 || occupancy !== 4'd0)
      begin errors++; $display("FAIL single_done got vld=%b occ=%0d exp 0/0", rxdat_vld, occupancy); end
  endtask

  task automatic test_full_and_stall;
    logic [2:0]  exp_id [8];
    logic [31:0] exp_addr [8];
    int          idx;
    logic        eb;
    logic        prev_stall;
    logic [2:0]  s_id;
    logic        s_beat;
    logic [31:0] s_lane0;
    for (int i = 0; i < 8; i++) begin
      exp_id[i]   = 3'(i + 1);
      exp_addr[i] = 32'h2000 + 32'(64 * (i + 1));
    end
    rxdat_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      txreq_vld = 1'b1; txreq_addr = 32'h2000 + 32'(64 * i); txreq_id = 3'(i);
      checks++; if (txreq_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_%0d got %b exp 1", i, txreq_rdy); end
      tick();
    end
    // 9th request waits for a slot
    txreq_addr = 32'h2200; txreq_id = 3'd0;
    checks++; if (txreq_rdy !== 1'b0 || occupancy !== 4'd8)
      begin errors++; $display("FAIL full_at8 got rdy=%b occ=%0d exp 0/8", txreq_rdy, occupancy); end
    checks++; if (rxdat_vld !== 1'b1 || rxdat_id !== 3'd0 || rxdat_beat !== 1'b0)
      begin errors++; $display("FAIL full_head got vld=%b id=%0d beat=%0d exp 1/0/0", rxdat_vld, rxdat_id, rxdat_beat); end
    rxdat_rdy = 1'b1;
    tick();   // last beat of head; handshake at next edge
    checks++; if (txreq_rdy !== 1'b0 || occupancy !== 4'd8 || rxdat_last !== 1'b1 || rxdat_data[31:0] !== 32'h2020)
      begin errors++; $display("FAIL full_lastbeat got rdy=%b occ=%0d last=%b lane0=%h exp 0/8/1/00002020", txreq_rdy, occupancy, rxdat_last, rxdat_data[31:0]); end
    tick();   // slot freed
    checks++; if (txreq_rdy !== 1'b1 || occupancy !== 4'd7)
      begin errors++; $display("FAIL full_freed got rdy=%b occ=%0d exp 1/7", txreq_rdy, occupancy); end
    checks++; if (rxdat_vld !== 1'b1 || rxdat_id !== 3'd1 || rxdat_beat !== 1'b0)
      begin errors++; $display("FAIL full_nobubble got vld=%b id=%0d beat=%0d exp 1/1/0", rxdat_vld, rxdat_id, rxdat_beat); end
    idx = 0; eb = 1'b0; prev_stall = 1'b0;
    s_id = '0; s_beat = 1'b0; s_lane0 = '0;
    for (int c = 0; c < 200 && idx < 8; c++) begin
      if (prev_stall) begin
        checks++;
        if (rxdat_vld !== 1'b1 || rxdat_id !== s_id || rxdat_beat !== s_beat || rxdat_data[31:0] !== s_lane0)
          begin errors++; $display("FAIL stall_stable cyc %0d got vld=%b id=%0d beat=%0d lane0=%h exp 1/%0d/%0d/%h", c, rxdat_vld, rxdat_id, rxdat_beat, rxdat_data[31:0], s_id, s_beat, s_lane0); end
      end
      rxdat_rdy = (c % 2 == 0);
      if (rxdat_vld && rxdat_rdy) begin
        checks++;
        if (rxdat_id !== exp_id[idx] || rxdat_beat !== eb || rxdat_last !== eb ||
            rxdat_data[31:0] !== exp_addr[idx] + (eb ? 32'h20 : 32'h0))
          begin errors++; $display("FAIL drain_beat %0d.%0d got id=%0d beat=%0d last=%b lane0=%h exp id=%0d lane0=%h", idx, eb, rxdat_id, rxdat_beat, rxdat_last, rxdat_data[31:0], exp_id[idx], exp_addr[idx] + (eb ? 32'h20 : 32'h0)); end
        if (eb) idx++;
        eb = ~eb;
      end
      prev_stall = rxdat_vld && !rxdat_rdy;
      s_id = rxdat_id; s_beat = rxdat_beat; s_lane0 = rxdat_data[31:0];
      tick();
      if (c == 0) begin
        txreq_vld = 1'b0;
        checks++; if (txreq_rdy !== 1'b0 || occupancy !== 4'd8)
          begin errors++; $display("FAIL refill got rdy=%b occ=%0d exp 0/8", txreq_rdy, occupancy); end
      end
    end
    checks++; if (idx != 8) begin errors++; $display("FAIL drain_timeout got %0d lines exp 8", idx); end
    rxdat_rdy = 1'b1;
    tick();
    checks++; if (occupancy !== 4'd0 || rxdat_vld !== 1'b0)
      begin errors++; $display("FAIL drain_empty got occ=%0d vld=%b exp 0/0", occupancy, rxdat_vld); end
  endtask

  task automatic test_reset_mid_burst;
    int waited;
    rxdat_rdy = 1'b1;
    txreq_vld = 1'b1; txreq_addr = 32'h3000; txreq_id = 3'd5;
    tick();
    txreq_vld = 1'b0;
    waited = 0;
    while (rxdat_vld !== 1'b1 && waited < 20) begin tick(); waited++; end
    checks++; if (rxdat_vld !== 1'b1) begin errors++; $display("FAIL rstmid_wait got vld=%b exp 1", rxdat_vld); end
    tick();   // beat 0 taken, now on beat 1
    rxdat_rdy = 1'b0;
    checks++; if (rxdat_beat !== 1'b1 || rxdat_vld !== 1'b1)
      begin errors++; $display("FAIL rstmid_b1 got vld=%b beat=%0d exp 1/1", rxdat_vld, rxdat_beat); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rxdat_vld !== 1'b0 || occupancy !== 4'd0 || txreq_rdy !== 1'b0)
      begin errors++; $display("FAIL rstmid_async got vld=%b occ=%0d rdy=%b exp 0/0/0", rxdat_vld, occupancy, txreq_rdy); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (txreq_rdy !== 1'b1 || occupancy !== 4'd0)
      begin errors++; $display("FAIL rstmid_release got rdy=%b occ=%0d exp 1/0", txreq_rdy, occupancy); end
    rxdat_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (rxdat_vld !== 1'b0) begin errors++; $display("FAIL rstmid_stale cyc %0d got vld=%b exp 0", c, rxdat_vld); end
    end
  endtask

`ifdef ICACHE_DN_VAR_LAT_EN
  task automatic test_var_latency;
    logic [2:0]  exp_id [4];
    logic [31:0] exp_lane [4];
    int          n;
    exp_id[0] = 3'd2; exp_lane[0] = 32'h0100;
    exp_id[1] = 3'd2; exp_lane[1] = 32'h0120;
    exp_id[2] = 3'd1; exp_lane[2] = 32'h00C0;
    exp_id[3] = 3'd1; exp_lane[3] = 32'h00E0;
    rxdat_rdy = 1'b1;
    txreq_vld = 1'b1; txreq_addr = 32'h00C0; txreq_id = 3'd1;
    tick();
    txreq_addr = 32'h0100; txreq_id = 3'd2;
    tick();
    txreq_vld = 1'b0;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      if (rxdat_vld) begin
        checks++;
        if (rxdat_id !== exp_id[n] || rxdat_data[31:0] !== exp_lane[n] || rxdat_beat !== 1'(n % 2))
          begin errors++; $display("FAIL var_beat %0d got id=%0d beat=%0d lane0=%h exp %0d/%0d/%h", n, rxdat_id, rxdat_beat, rxdat_data[31:0], exp_id[n], n % 2, exp_lane[n]); end
        n++;
      end
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL var_timeout got %0d beats exp 4", n); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full_and_stall();
    test_reset_mid_burst();
`ifdef ICACHE_DN_VAR_LAT_EN
    test_var_latency();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
